// File: rtl/reg_file.sv
// Architectural integer register file: 2 combinational read ports, busy scoreboard, retire counter.
// Latency: reads/stall combinational (same-cycle write-back bypass); writes and busy updates land at the next edge.
// Backpressure: reg_file_o_stall holds decode while any source operand is busy; issue during stall is ignored.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   decode_i_rs1/rs2                read addresses; reg_file_o_rs1_data/rs2_data read data
//   decode_i_issue/decode_i_rd      issued instruction and its destination (marks rd busy)
//   write_back_i_reg_wen/rd/reg_data  register write port (clears busy)
//   write_back_i_commit             one instruction retires; reg_file_o_instret counts them
//   reg_file_o_stall                an operand is still outstanding
// Build option: define REG_FILE_RV32E_EN for a 16-entry RV32E file (addresses with bit 4 set
// read as 0, never write, never become busy, never stall).
module reg_file #(
   parameter int INSTRET_W = 64
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           decode_i_rs1,
   input  logic [4:0]           decode_i_rs2,
   input  logic                 decode_i_issue,
   input  logic [4:0]           decode_i_rd,
   input  logic                 write_back_i_reg_wen,
   input  logic [4:0]           write_back_i_rd,
   input  logic [31:0]          write_back_i_reg_data,
   input  logic                 write_back_i_commit,
   output logic [31:0]          reg_file_o_rs1_data,
   output logic [31:0]          reg_file_o_rs2_data,
   output logic                 reg_file_o_stall,
   output logic [INSTRET_W-1:0] reg_file_o_instret
);

`ifdef REG_FILE_RV32E_EN
   localparam int NREG  = 16;
   localparam bit RV32E = 1'b1;
`else
   localparam int NREG  = 32;
   localparam bit RV32E = 1'b0;
`endif
   localparam int AW = $clog2(NREG);

   logic [31:0]          regs [NREG];
   logic [NREG-1:0]      busy;
   logic [INSTRET_W-1:0] instret_cnt;

   logic          wb_ok;
   logic          byp1, byp2;
   logic          hit1, hit2;
   logic          issue_ok;
   logic [AW-1:0] rs1_idx, rs2_idx, wb_idx, rd_idx;

   // An address names real storage only if it is non-zero and, in RV32E, below 16.
   function automatic logic addr_ok(input logic [4:0] a);
      return (a != 5'd0) && !(RV32E && a[4]);
   endfunction

   assign rs1_idx = decode_i_rs1[AW-1:0];
   assign rs2_idx = decode_i_rs2[AW-1:0];
   assign wb_idx  = write_back_i_rd[AW-1:0];
   assign rd_idx  = decode_i_rd[AW-1:0];

   always_comb begin
      wb_ok = write_back_i_reg_wen && addr_ok(write_back_i_rd);
      // Bypass only for valid addresses; wb_ok already excludes x0 and out-of-range rd.
      byp1  = wb_ok && (write_back_i_rd == decode_i_rs1);
      byp2  = wb_ok && (write_back_i_rd == decode_i_rs2);

      reg_file_o_rs1_data = '0;
      reg_file_o_rs2_data = '0;
      if (addr_ok(decode_i_rs1))
         reg_file_o_rs1_data = byp1 ? write_back_i_reg_data : regs[rs1_idx];
      if (addr_ok(decode_i_rs2))
         reg_file_o_rs2_data = byp2 ? write_back_i_reg_data : regs[rs2_idx];

      // A busy operand being written back this cycle is already available via bypass.
      hit1 = addr_ok(decode_i_rs1) && busy[rs1_idx] && !byp1;
      hit2 = addr_ok(decode_i_rs2) && busy[rs2_idx] && !byp2;
      reg_file_o_stall = hit1 || hit2;

      issue_ok = decode_i_issue && !reg_file_o_stall && addr_ok(decode_i_rd);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
         busy        <= '0;
         instret_cnt <= '0;
      end else begin
         if (wb_ok) begin
            regs[wb_idx] <= write_back_i_reg_data;
            busy[wb_idx] <= 1'b0;
         end
         // Placed after the clear so a same-cycle issue to the same rd wins (it is younger).
         if (issue_ok)
            busy[rd_idx] <= 1'b1;
         if (write_back_i_commit)
            instret_cnt <= instret_cnt + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
   end

   assign reg_file_o_instret = instret_cnt;

endmodule

// File: doc/reg_file.md
# reg_file

Architectural integer register file for the multi-cycle NPC core; it is the receiving end of the write-back stage's register write port. It holds x0..x31, serves two combinational read ports to decode with same-cycle write-back bypass, and keeps a per-register busy scoreboard so decode stalls on operands whose write-back is still outstanding. It also counts committed instructions in a retire counter.

## Interface
- INSTRET_W, 64, width of the retire counter
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- decode_i_rs1  input  5  read address, port 1
- decode_i_rs2  input  5  read address, port 2
- decode_i_issue  input  1  decode issues an instruction that will write decode_i_rd
- decode_i_rd  input  5  destination register of the issued instruction
- write_back_i_reg_wen  input  1  register write enable from write-back (already gated by commit)
- write_back_i_rd  input  5  write address
- write_back_i_reg_data  input  32  write data
- write_back_i_commit  input  1  one instruction retires this cycle
- reg_file_o_rs1_data  output  32  read data, port 1
- reg_file_o_rs2_data  output  32  read data, port 2
- reg_file_o_stall  output  1  an operand is busy; decode must hold
- reg_file_o_instret  output  INSTRET_W  retired-instruction count

## Operation
- Storage: 32 x 32-bit; x0 reads 0 always; writes to x0 dropped.
- Write: at rising edge, if write_back_i_reg_wen && write_back_i_rd != 0, regs[write_back_i_rd] <= write_back_i_reg_data. Writing a non-busy register is legal.
- Read (combinational): rsN == 0 -> 0; else if write_back_i_reg_wen && write_back_i_rd == rsN -> write_back_i_reg_data (bypass); else regs[rsN].
- Scoreboard busy[31:0], busy[0] constant 0.
  - Set: decode_i_issue && !reg_file_o_stall && decode_i_rd != 0 -> busy[decode_i_rd] <= 1. Issue while stall is high is ignored.
  - Clear: write_back_i_reg_wen && write_back_i_rd != 0 -> busy[write_back_i_rd] <= 0.
  - Set and clear of same index in one cycle: set wins (issue is younger).
- Stall (combinational): hitN = busy[rsN] && !(write_back_i_reg_wen && write_back_i_rd == rsN); reg_file_o_stall = hit1 || hit2. Stall does not depend on decode_i_issue.
- Retire counter: +1 each edge with write_back_i_commit == 1; wraps from all-ones to 0. Independent of reg_wen (stores/branches count).

## Timing
- Reset (rst_n low at an edge): all registers 0, busy all 0, instret 0. After that edge: rs1/rs2 data 0, stall 0, instret 0. Reset asserted mid-operation discards in-flight writes and busy bits that edge.
- Write latency: data visible on read ports the same cycle via bypass, from regs the next cycle.
- Busy set visible on stall the cycle after issue; clear releases stall combinationally in the write-back cycle.
- Read ports and stall have no registered delay; no input-to-output path through decode_i_issue.
- Simultaneous rs1 == rs2: both ports return same value; stall asserted once.

## Configuration
- REG_FILE_RV32E_EN defined: RV32E file, 16 registers. Any address with bit 4 set: read returns 0, write dropped, busy not set, bypass not taken, never stalls. Storage and busy vector are 16 entries.
- Not defined: full 32-register RV32I file as described above.

## Test plan
- Reset then read x1..x31 -> all 0; stall 0; instret 0.
- Write x5 = 0xDEADBEEF with rs1 = 5 same cycle -> rs1_data 0xDEADBEEF via bypass that cycle and from storage next cycle; write x0 = 0x1234 -> x0 reads 0.
- Issue rd = 7, next cycle rs2 = 7 -> stall 1; hold until write_back wen rd = 7 data 0x55 -> stall 0 and rs2_data 0x55 that cycle; busy[7] 0 after.
- Same cycle: write_back clears x3 and issue sets x3 -> busy[3] 1, next cycle rs1 = 3 stalls; issue rd = 9 while stall high -> busy[9] stays 0.
- Assert commit 10 cycles with wen 0 on 4 of them -> instret 10; preload instret all-ones (force) and commit once -> 0.
- With REG_FILE_RV32E_EN: write x17 = 0xFFFF, read rs1 = 17 -> 0; issue rd = 20, read rs1 = 20 -> no stall.
